// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one datamemory between the CPU load/store path (port 0)
// and the CNN loader (port 1); registered read return and saturating grant counters.
module dmem_rr_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [CNT_W-1:0]  grant0_cnt,
    output logic [CNT_W-1:0]  grant1_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              last_grant;
    logic              grant0;
    logic              grant1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    // On a tie the port that did not win last time goes; last_grant resets to 1 so port 0 wins first.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready    = grant0;
    assign req1_ready    = grant1;
    assign mem_address   = grant1 ? req1_addr  : req0_addr;
    assign mem_writedata = grant1 ? req1_wdata : req0_wdata;
    assign mem_memwrite  = (grant0 && req0_write)  || (grant1 && req1_write);
    assign mem_memread   = (grant0 && !req0_write) || (grant1 && !req1_write);

    assign req0_rvalid = rvalid0;
    assign req1_rvalid = rvalid1;
    assign req0_rdata  = rdata0;
    assign req1_rdata  = rdata1;

    // rdataN only changes on a read grant to port N, so it holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            grant0_cnt <= '0;
            grant1_cnt <= '0;
        end else begin
            rvalid0 <= grant0 && !req0_write;
            rvalid1 <= grant1 && !req1_write;
            if (grant0 && !req0_write) begin
                rdata0 <= mem_readdata;
            end
            if (grant1 && !req1_write) begin
                rdata1 <= mem_readdata;
            end
            if (grant0 || grant1) begin
                last_grant <= grant1;
            end
            if (grant0 && grant0_cnt != CNT_MAX) begin
                grant0_cnt <= grant0_cnt + CNT_W'(1);
            end
            if (grant1 && grant1_cnt != CNT_MAX) begin
                grant1_cnt <= grant1_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Bench for dmem_rr_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (winner choice, shadow memory, one-cycle read return).
module tb_dmem_rr_arbiter;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b0;
    logic              req0_valid = 1'b0, req0_write = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic [DATA_W-1:0] req0_wdata = '0;
    logic              req1_valid = 1'b0, req1_write = 1'b0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic [DATA_W-1:0] req1_wdata = '0;
    logic              req0_ready, req0_rvalid, req1_ready, req1_rvalid;
    logic [DATA_W-1:0] req0_rdata, req1_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writedata, mem_readdata;
    logic              mem_memread, mem_memwrite;
    logic [CNT_W-1:0]  grant0_cnt, grant1_cnt;

    // Second instance with 2-bit counters so saturation is reachable quickly.
    logic              s_req0_valid = 1'b0;
    logic              s_req0_ready, s_req0_rvalid, s_req1_ready, s_req1_rvalid;
    logic [DATA_W-1:0] s_req0_rdata, s_req1_rdata;
    logic [ADDR_W-1:0] s_mem_address;
    logic [DATA_W-1:0] s_mem_writedata;
    logic              s_mem_memread, s_mem_memwrite;
    logic [1:0]        s_grant0_cnt, s_grant1_cnt;

    int checks = 0;
    int failures = 0;

    // Combinational-read memory standing in for datamemory.
    logic [DATA_W-1:0] env_mem [0:1023] = '{default: '0};
    assign mem_readdata = env_mem[mem_address];
    always @(posedge clk) if (mem_memwrite) env_mem[mem_address] <= mem_writedata;

    dmem_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
        .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
        .req1_rdata(req1_rdata),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_readdata(mem_readdata),
        .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt)
    );

    dmem_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .req0_valid(s_req0_valid), .req0_write(1'b0), .req0_addr(10'h000),
        .req0_wdata(32'h0), .req0_ready(s_req0_ready), .req0_rvalid(s_req0_rvalid),
        .req0_rdata(s_req0_rdata),
        .req1_valid(1'b0), .req1_write(1'b0), .req1_addr(10'h000),
        .req1_wdata(32'h0), .req1_ready(s_req1_ready), .req1_rvalid(s_req1_rvalid),
        .req1_rdata(s_req1_rdata),
        .mem_address(s_mem_address), .mem_writedata(s_mem_writedata),
        .mem_memread(s_mem_memread), .mem_memwrite(s_mem_memwrite),
        .mem_readdata(32'h0),
        .grant0_cnt(s_grant0_cnt), .grant1_cnt(s_grant1_cnt)
    );

    // Reference model state (transaction level).
    int                m_last = 1;
    int                m_cnt0 = 0, m_cnt1 = 0;
    bit                m_rv0 = 0, m_rv1 = 0;
    logic [DATA_W-1:0] m_rd0 = '0, m_rd1 = '0;
    logic [DATA_W-1:0] m_mem [0:1023] = '{default: '0};

    // Expected combinational response for the cycle just driven.
    int                e_win;
    bit                e_ready0, e_ready1, e_mread, e_mwrite;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;

    bit                pend = 0;
    bit                p_rst, p_w0, p_w1;
    int                p_win;
    logic [ADDR_W-1:0] p_a0, p_a1;
    logic [DATA_W-1:0] p_d0, p_d1;

    task automatic model_commit();
        if (p_rst) begin
            m_last = 1; m_rv0 = 0; m_rv1 = 0; m_rd0 = '0; m_rd1 = '0; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            m_rv0 = 0;
            m_rv1 = 0;
            if (p_win == 0) begin
                if (p_w0) m_mem[p_a0] = p_d0;
                else begin m_rv0 = 1; m_rd0 = m_mem[p_a0]; end
                if (m_cnt0 < CNT_MAX) m_cnt0++;
                m_last = 0;
            end else if (p_win == 1) begin
                if (p_w1) m_mem[p_a1] = p_d1;
                else begin m_rv1 = 1; m_rd1 = m_mem[p_a1]; end
                if (m_cnt1 < CNT_MAX) m_cnt1++;
                m_last = 1;
            end
        end
        pend = 0;
    endtask

    task automatic apply(input bit rst,
                         input bit v0, input bit w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input bit v1, input bit w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        if (pend) model_commit();
        @(negedge clk);
        reset = rst;
        req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1;
        #1;
        e_win = -1;
        if (!rst) begin
            if (v0 && v1) e_win = 1 - m_last;
            else if (v0)  e_win = 0;
            else if (v1)  e_win = 1;
        end
        e_ready0 = (e_win == 0);
        e_ready1 = (e_win == 1);
        e_mwrite = (e_win == 0) ? w0 : (e_win == 1) ? w1 : 1'b0;
        e_mread  = (e_win >= 0) && !e_mwrite;
        e_addr   = (e_win == 1) ? a1 : a0;
        e_wdata  = (e_win == 1) ? d1 : d0;
        p_rst = rst; p_win = e_win;
        p_w0 = w0; p_a0 = a0; p_d0 = d0;
        p_w1 = w1; p_a1 = a1; p_d1 = d1;
        pend = 1;
    endtask

    task automatic idle(input bit rst);
        apply(rst, 0, 0, 10'h000, 32'h0, 0, 0, 10'h000, 32'h0);
    endtask

    task automatic test_reset();
        apply(1, 1, 0, 10'h001, 32'h0, 1, 1, 10'h002, 32'h1234);
        checks++;
        if ({req0_ready, req1_ready, mem_memread, mem_memwrite} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_strobes: got %b expected 0000",
                     {req0_ready, req1_ready, mem_memread, mem_memwrite});
        end
        idle(1);
        idle(0);
        checks++;
        if ({req0_rvalid, req1_rvalid} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_rvalid: got %b expected 00", {req0_rvalid, req1_rvalid});
        end
        checks++;
        if (grant0_cnt !== 16'd0 || grant1_cnt !== 16'd0 || req0_rdata !== 32'h0 || req1_rdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_state: got cnt %0d/%0d rdata %h/%h expected 0/0 0/0",
                     grant0_cnt, grant1_cnt, req0_rdata, req1_rdata);
        end
    endtask

    task automatic test_single_read();
        apply(0, 1, 1, 10'h000, 32'hC00000F0, 0, 0, 10'h000, 32'h0);
        checks++;
        if (req0_ready !== 1'b1 || mem_memwrite !== 1'b1 || mem_memread !== 1'b0) begin
            failures++;
            $display("[TB] FAIL preload_write: got ready=%b wr=%b rd=%b expected 1 1 0",
                     req0_ready, mem_memwrite, mem_memread);
        end
        apply(0, 1, 0, 10'h000, 32'h0, 0, 0, 10'h000, 32'h0);
        checks++;
        if (req0_ready !== 1'b1 || mem_memread !== 1'b1 || mem_address !== 10'h000) begin
            failures++;
            $display("[TB] FAIL single_read_grant: got ready=%b rd=%b addr=%h expected 1 1 000",
                     req0_ready, mem_memread, mem_address);
        end
        idle(0);
        checks++;
        if (req0_rvalid !== 1'b1 || req0_rdata !== 32'hC00000F0 || req1_rvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_read_data: got rv0=%b rdata=%h rv1=%b expected 1 c00000f0 0",
                     req0_rvalid, req0_rdata, req1_rvalid);
        end
    endtask

    task automatic test_alternation();
        idle(1);
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, 0, 10'h001, 32'h0, 1, 0, 10'h145, 32'h0);
            checks++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                failures++;
                $display("[TB] FAIL alternation_%0d: got ready0=%b ready1=%b expected %b %b",
                         i, req0_ready, req1_ready, i % 2 == 0, i % 2 == 1);
            end
        end
        idle(0);
        checks++;
        if (grant0_cnt !== 16'd2 || grant1_cnt !== 16'd2) begin
            failures++;
            $display("[TB] FAIL alternation_cnt: got %0d/%0d expected 2/2", grant0_cnt, grant1_cnt);
        end
    endtask

    task automatic test_mixed_write_read();
        apply(0, 1, 1, 10'h2E0, 32'hC7030F00, 0, 0, 10'h000, 32'h0);
        idle(1);
        apply(0, 1, 0, 10'h2E0, 32'h0, 1, 1, 10'h305, 32'h90600F00);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mixed_first: got ready0=%b ready1=%b expected 1 0", req0_ready, req1_ready);
        end
        apply(0, 0, 0, 10'h000, 32'h0, 1, 1, 10'h305, 32'h90600F00);
        checks++;
        if (req1_ready !== 1'b1 || mem_memwrite !== 1'b1 || mem_memread !== 1'b0 ||
            mem_writedata !== 32'h90600F00) begin
            failures++;
            $display("[TB] FAIL mixed_write: got ready1=%b wr=%b rd=%b wdata=%h expected 1 1 0 90600f00",
                     req1_ready, mem_memwrite, mem_memread, mem_writedata);
        end
        checks++;
        if (req0_rvalid !== 1'b1 || req0_rdata !== 32'hC7030F00) begin
            failures++;
            $display("[TB] FAIL mixed_read0: got rv0=%b rdata=%h expected 1 c7030f00", req0_rvalid, req0_rdata);
        end
        apply(0, 0, 0, 10'h000, 32'h0, 1, 0, 10'h305, 32'h0);
        idle(0);
        checks++;
        if (req1_rvalid !== 1'b1 || req1_rdata !== 32'h90600F00) begin
            failures++;
            $display("[TB] FAIL mixed_raw: got rv1=%b rdata=%h expected 1 90600f00", req1_rvalid, req1_rdata);
        end
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 3; i++) begin
            idle(0);
            checks++;
            if ({mem_memread, mem_memwrite, req0_ready, req1_ready} !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL idle_%0d: got %b expected 0000", i,
                         {mem_memread, mem_memwrite, req0_ready, req1_ready});
            end
        end
        // Last grant before the idle run was port 1, so port 0 must win this tie.
        apply(0, 1, 0, 10'h000, 32'h0, 1, 0, 10'h305, 32'h0);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_tie: got ready0=%b ready1=%b expected 1 0", req0_ready, req1_ready);
        end
        apply(0, 1, 0, 10'h2E0, 32'h0, 1, 0, 10'h305, 32'h0);
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || mem_address !== 10'h305) begin
            failures++;
            $display("[TB] FAIL hold_grant1: got ready1=%b ready0=%b addr=%h expected 1 0 305",
                     req1_ready, req0_ready, mem_address);
        end
        apply(0, 1, 0, 10'h2E0, 32'h0, 0, 0, 10'h000, 32'h0);
        checks++;
        if (req0_ready !== 1'b1 || req1_rvalid !== 1'b1 || req1_rdata !== 32'h90600F00) begin
            failures++;
            $display("[TB] FAIL hold_grant0: got ready0=%b rv1=%b rdata1=%h expected 1 1 90600f00",
                     req0_ready, req1_rvalid, req1_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        apply(0, 1, 0, 10'h000, 32'h0, 0, 0, 10'h000, 32'h0);
        idle(1);
        idle(0);
        checks++;
        if (req0_rvalid !== 1'b0 || grant0_cnt !== 16'd0 || grant1_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_read: got rv0=%b cnt=%0d/%0d expected 0 0/0",
                     req0_rvalid, grant0_cnt, grant1_cnt);
        end
        apply(0, 1, 0, 10'h001, 32'h0, 1, 0, 10'h145, 32'h0);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_first_tie: got ready0=%b ready1=%b expected 1 0", req0_ready, req1_ready);
        end
    endtask

    task automatic test_random();
        bit                pv0 = 0, pv1 = 0, pw0 = 0, pw1 = 0, rst;
        logic [ADDR_W-1:0] pa0 = '0, pa1 = '0;
        logic [DATA_W-1:0] pd0 = '0, pd1 = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pv0 && $urandom_range(0, 2) != 0) begin
                pv0 = 1; pw0 = $urandom_range(0, 1) == 1;
                pa0 = ADDR_W'($urandom_range(0, 7)); pd0 = $urandom;
            end
            if (!pv1 && $urandom_range(0, 2) != 0) begin
                pv1 = 1; pw1 = $urandom_range(0, 1) == 1;
                pa1 = ADDR_W'($urandom_range(0, 7)); pd1 = $urandom;
            end
            rst = ($urandom_range(0, 49) == 0);
            apply(rst, pv0, pw0, pa0, pd0, pv1, pw1, pa1, pd1);
            checks++;
            if ({req0_ready, req1_ready, mem_memread, mem_memwrite} !== {e_ready0, e_ready1, e_mread, e_mwrite}) begin
                failures++;
                $display("[TB] FAIL rand_strobes n=%0d: got %b expected %b", n,
                         {req0_ready, req1_ready, mem_memread, mem_memwrite}, {e_ready0, e_ready1, e_mread, e_mwrite});
            end
            if (e_win >= 0) begin
                checks++;
                if (mem_address !== e_addr || (e_mwrite && mem_writedata !== e_wdata)) begin
                    failures++;
                    $display("[TB] FAIL rand_mem n=%0d: got addr=%h wdata=%h expected %h %h", n,
                             mem_address, mem_writedata, e_addr, e_wdata);
                end
            end
            checks++;
            if ({req0_rvalid, req1_rvalid} !== {m_rv0, m_rv1} || req0_rdata !== m_rd0 || req1_rdata !== m_rd1) begin
                failures++;
                $display("[TB] FAIL rand_read n=%0d: got rv=%b rd=%h/%h expected %b %h/%h", n,
                         {req0_rvalid, req1_rvalid}, req0_rdata, req1_rdata, {m_rv0, m_rv1}, m_rd0, m_rd1);
            end
            checks++;
            if (grant0_cnt !== CNT_W'(m_cnt0) || grant1_cnt !== CNT_W'(m_cnt1)) begin
                failures++;
                $display("[TB] FAIL rand_cnt n=%0d: got %0d/%0d expected %0d/%0d", n,
                         grant0_cnt, grant1_cnt, m_cnt0, m_cnt1);
            end
            if (e_ready0) pv0 = 0;
            if (e_ready1) pv1 = 0;
        end
        idle(0);
    endtask

    task automatic test_saturation();
        int exp_cnt;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            s_req0_valid = (k < 6);
            #1;
            exp_cnt = (k < 3) ? k : 3;
            checks++;
            if (s_grant0_cnt !== 2'(exp_cnt)) begin
                failures++;
                $display("[TB] FAIL sat_cnt_%0d: got %0d expected %0d", k, s_grant0_cnt, exp_cnt);
            end
            if (k < 6) begin
                checks++;
                if (s_req0_ready !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL sat_ready_%0d: got %b expected 1", k, s_req0_ready);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_alternation();
        test_mixed_write_read();
        test_idle_hold();
        test_reset_mid_read();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
